// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry block: key codes, row strobes,
// FSM and press-count encodings, the key map and the BCD edit rule.
package keypad_pkg;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam logic [3:0] ROW0 = 4'b1110;
  localparam logic [3:0] ROW1 = 4'b1101;
  localparam logic [3:0] ROW2 = 4'b1011;
  localparam logic [3:0] ROW3 = 4'b0111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PRESS_NONE  = 2'd0,
    PRESS_ONE   = 2'd1,
    PRESS_MULTI = 2'd2
  } press_e;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = KEY_A;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = KEY_B;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = KEY_C;
      4'd12:   code = KEY_STAR;
      4'd13:   code = 4'h0;
      4'd14:   code = KEY_HASH;
      4'd15:   code = KEY_D;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] row_strobe(input logic [1:0] row);
    logic [3:0] strobe;
    case (row)
      2'd0:    strobe = ROW0;
      2'd1:    strobe = ROW1;
      2'd2:    strobe = ROW2;
      2'd3:    strobe = ROW3;
      default: strobe = ROW0;
    endcase
    return strobe;
  endfunction

  // Digits shift in from the right; A clears, B drops the newest digit.
  function automatic logic [15:0] bcd_apply(input logic [15:0] d, input logic [3:0] code);
    logic [15:0] res;
    if (code <= 4'd9) begin
      res = {d[11:0], code};
    end else if (code == KEY_A) begin
      res = 16'h0000;
    end else if (code == KEY_B) begin
      res = {4'h0, d[15:4]};
    end else begin
      res = d;
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_bcd_entry_if.sv
// Keypad matrix pins plus the entry result bus, shared between the entry
// block (master) and whatever drives the keypad / consumes the digits (slave).
interface keypad_bcd_entry_if;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] digits;
  logic [3:0]  key_code;
  logic        key_valid;

  modport master (input col_n, output row_n, output digits, output key_code, output key_valid);
  modport slave  (output col_n, input row_n, input digits, input key_code, input key_valid);
endinterface

// File: rtl/keypad_row_scanner.sv
// Rotates the row strobe, synchronises and samples the columns, and reports a
// per-round press summary on the last cycle of row 3.
module keypad_row_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       round_done,
  output press_e     press,
  output logic [3:0] code
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_r;
  logic [1:0]       row_r;
  logic [3:0]       row_n_r;
  logic [3:0]       col_s1_r;
  logic [3:0]       col_s2_r;
  press_e           acc_press_r;
  logic [3:0]       acc_code_r;

  logic             last_s;
  logic [2:0]       hit_cnt_s;
  logic [1:0]       hit_col_s;
  press_e           press_nxt_s;
  logic [3:0]       code_nxt_s;

  assign last_s     = (div_r == DIV_LAST);
  assign row_n      = row_n_r;
  assign round_done = last_s && (row_r == 2'd3);
  assign press      = press_nxt_s;
  assign code       = code_nxt_s;

  // Count pressed columns in the current row and remember one of them.
  always_comb begin
    hit_cnt_s = 3'd0;
    hit_col_s = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      hit_cnt_s = hit_cnt_s + {2'b00, ~col_s2_r[c]};
      hit_col_s = col_s2_r[c] ? hit_col_s : 2'(c);
    end
  end

  // Fold this row's hits into the running round summary.
  always_comb begin
    press_nxt_s = acc_press_r;
    code_nxt_s  = acc_code_r;
    if (hit_cnt_s == 3'd0) begin
      press_nxt_s = acc_press_r;
    end else if ((hit_cnt_s == 3'd1) && (acc_press_r == PRESS_NONE)) begin
      press_nxt_s = PRESS_ONE;
      code_nxt_s  = key_map(row_r, hit_col_s);
    end else begin
      press_nxt_s = PRESS_MULTI;
    end
  end

  // Divider, row rotation, column synchroniser and round accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r       <= '0;
      row_r       <= 2'd0;
      row_n_r     <= ROW0;
      col_s1_r    <= 4'b1111;
      col_s2_r    <= 4'b1111;
      acc_press_r <= PRESS_NONE;
      acc_code_r  <= 4'h0;
    end else begin
      col_s1_r <= col_n;
      col_s2_r <= col_s1_r;
      if (last_s) begin
        div_r   <= '0;
        row_r   <= row_r + 2'd1;
        row_n_r <= row_strobe(row_r + 2'd1);
        if (row_r == 2'd3) begin
          acc_press_r <= PRESS_NONE;
          acc_code_r  <= 4'h0;
        end else begin
          acc_press_r <= press_nxt_s;
          acc_code_r  <= code_nxt_s;
        end
      end else begin
        div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/keypad_bcd_entry.sv
// Keypad-to-BCD entry: debounces round summaries from the row scanner and
// edits a 4-digit packed-BCD register on each accepted key.
module keypad_bcd_entry
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input logic               clk,
  input logic               rst,
  keypad_bcd_entry_if.master bus
);

  localparam logic [15:0] DEB_LIM = 16'(DEBOUNCE_CNT);

  logic        round_done_s;
  press_e      press_s;
  logic [3:0]  code_s;

  state_e      state_r;
  state_e      state_nxt_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic [3:0]  cand_r;
  logic [3:0]  cand_nxt_s;
  logic        accept_s;
  logic [15:0] digits_r;
  logic [3:0]  key_code_r;
  logic        key_valid_r;

  keypad_row_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk        (clk),
    .rst        (rst),
    .col_n      (bus.col_n),
    .row_n      (bus.row_n),
    .round_done (round_done_s),
    .press      (press_s),
    .code       (code_s)
  );

  assign bus.digits    = digits_r;
  assign bus.key_code  = key_code_r;
  assign bus.key_valid = key_valid_r;

  // Debounce FSM: only moves when a scan round completes.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    cand_nxt_s  = cand_r;
    accept_s    = 1'b0;
    if (round_done_s) begin
      case (state_r)
        IDLE: begin
          if (press_s == PRESS_ONE) begin
            cand_nxt_s = code_s;
            cnt_nxt_s  = 16'd1;
            if (DEB_LIM == 16'd1) begin
              accept_s    = 1'b1;
              state_nxt_s = HELD;
            end else begin
              state_nxt_s = DEBOUNCE;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        DEBOUNCE: begin
          if ((press_s == PRESS_ONE) && (code_s == cand_r)) begin
            cnt_nxt_s = cnt_r + 16'd1;
            if ((cnt_r + 16'd1) == DEB_LIM) begin
              accept_s    = 1'b1;
              state_nxt_s = HELD;
            end else begin
              state_nxt_s = DEBOUNCE;
            end
          end else begin
            cnt_nxt_s   = 16'd0;
            state_nxt_s = IDLE;
          end
        end
        HELD: begin
          if (press_s == PRESS_NONE) begin
            cnt_nxt_s   = 16'd0;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = HELD;
          end
        end
        default: begin
          cnt_nxt_s   = 16'd0;
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 16'd0;
      cand_r      <= 4'h0;
      digits_r    <= 16'h0000;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      cand_r  <= cand_nxt_s;
      if (accept_s) begin
        key_valid_r <= 1'b1;
        key_code_r  <= cand_nxt_s;
        digits_r    <= bcd_apply(digits_r, cand_nxt_s);
      end else begin
        key_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Bench for keypad_bcd_entry: a keypad matrix model, a round-level reference
// of debounce and decimal entry, table-driven presses, corner cases and random.
module tb_keypad_bcd_entry;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int ROUND    = 4 * SCAN_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_bcd_entry_if bus();

  keypad_bcd_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Pressed-key bitmap, bit index = row*4 + col.
  logic [15:0] pressed = 16'h0000;
  logic [3:0]  col_s;
  logic [3:0]  code_at [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

  always_comb begin
    col_s = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (bus.row_n[r] == 1'b0)) col_s[c] = 1'b0;
  end
  assign bus.col_n = col_s;

  int n_pass  = 0;
  int n_total = 0;
  int acc_seen = 0;

  // Reference: decimal value 0..9999, last code, held lock, streak of one key.
  int         m_val;
  logic [3:0] m_code;
  bit         m_locked;
  int         m_len;
  logic [3:0] m_cand;
  bit         m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] mask(input logic [3:0] code);
    logic [15:0] m = 16'h0000;
    for (int i = 0; i < 16; i++) if (code_at[i] == code) m[i] = 1'b1;
    return m;
  endfunction

  function automatic void model_reset();
    m_val = 0; m_code = 4'h0; m_locked = 1'b0; m_len = 0; m_cand = 4'h0; m_acc = 1'b0;
  endfunction

  function automatic void model_round(input logic [15:0] keys);
    int n = $countones(keys);
    logic [3:0] k = 4'h0;
    for (int i = 0; i < 16; i++) if (keys[i]) k = code_at[i];
    m_acc = 1'b0;
    if (m_locked) begin
      if (n == 0) m_locked = 1'b0;
    end else if (n == 1) begin
      if (m_len > 0 && k != m_cand) m_len = 0;
      else begin
        if (m_len == 0) m_cand = k;
        m_len++;
        if (m_len == DEB) begin
          m_acc = 1'b1; m_locked = 1'b1; m_len = 0; m_code = k;
          if (k <= 4'd9) m_val = (m_val * 10 + int'(k)) % 10000;
          else if (k == 4'hA) m_val = 0;
          else if (k == 4'hB) m_val = m_val / 10;
        end
      end
    end else begin
      m_len = 0;
    end
  endfunction

  // Called at the negedge of cycle 0 of a round; returns at cycle 0 of the next.
  task automatic run_round(input logic [15:0] keys, input int rst_at);
    bit kv_bad = 1'b0;
    bit row_bad = 1'b0;
    logic [3:0] exp_row;
    check("key_valid at round start", bus.key_valid, m_acc);
    check("key_code", bus.key_code, m_code);
    check("digits", bus.digits, to_bcd(m_val));
    if (bus.key_valid === 1'b1) acc_seen++;
    if (bus.row_n !== 4'b1110) row_bad = 1'b1;
    pressed = keys;
    model_round(keys);
    for (int i = 1; i < ROUND; i++) begin
      @(negedge clk);
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("reset row_n", bus.row_n, 4'b1110);
        check("reset key_valid", bus.key_valid, 1'b0);
        check("reset key_code", bus.key_code, 4'h0);
        check("reset digits", bus.digits, 16'h0000);
        check("row sequence before reset", row_bad, 1'b0);
        return;
      end
      exp_row = 4'b0001 << (i / SCAN_DIV);
      if (bus.key_valid !== 1'b0) kv_bad = 1'b1;
      if (bus.row_n !== ~exp_row) row_bad = 1'b1;
    end
    check("row sequence", row_bad, 1'b0);
    check("key_valid mid-round", kv_bad, 1'b0);
    @(negedge clk);
  endtask

  task automatic hold(input logic [15:0] keys, input int rounds);
    for (int r = 0; r < rounds; r++) run_round(keys, 0);
  endtask

  typedef struct {
    logic [3:0]  code;
    int          rounds;
    int          exp_acc;
    logic [3:0]  exp_code;
    logic [15:0] exp_digits;
  } step_t;

  step_t steps [16];

  initial begin
    steps[0]  = '{4'h5, 3, 1, 4'h5, 16'h0005};
    steps[1]  = '{4'h0, 3, 1, 4'h0, 16'h0050};
    steps[2]  = '{4'h7, 3, 1, 4'h7, 16'h0507};
    steps[3]  = '{4'hA, 2, 1, 4'hA, 16'h0000};
    steps[4]  = '{4'h1, 2, 1, 4'h1, 16'h0001};
    steps[5]  = '{4'h2, 3, 1, 4'h2, 16'h0012};
    steps[6]  = '{4'h3, 2, 1, 4'h3, 16'h0123};
    steps[7]  = '{4'h4, 2, 1, 4'h4, 16'h1234};
    steps[8]  = '{4'h9, 2, 1, 4'h9, 16'h2349};
    steps[9]  = '{4'hB, 3, 1, 4'hB, 16'h0234};
    steps[10] = '{4'hA, 2, 1, 4'hA, 16'h0000};
    steps[11] = '{4'h3, 1, 0, 4'hA, 16'h0000};
    steps[12] = '{4'hD, 2, 1, 4'hD, 16'h0000};
    steps[13] = '{4'hE, 2, 1, 4'hE, 16'h0000};
    steps[14] = '{4'hF, 2, 1, 4'hF, 16'h0000};
    steps[15] = '{4'h8, 1, 0, 4'hF, 16'h0000};

    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle scanning with no key.
    acc_seen = 0;
    hold(16'h0000, 3);
    check("idle accepts", acc_seen, 0);

    // Table of single presses, each followed by a release round.
    for (int s = 0; s < 16; s++) begin
      acc_seen = 0;
      hold(mask(steps[s].code), steps[s].rounds);
      hold(16'h0000, 1);
      check($sformatf("step %0d accepts", s), acc_seen, steps[s].exp_acc);
      check($sformatf("step %0d key_code", s), bus.key_code, steps[s].exp_code);
      check($sformatf("step %0d digits", s), bus.digits, steps[s].exp_digits);
    end

    // Different single keys in consecutive rounds never debounce.
    acc_seen = 0;
    hold(mask(4'h3), 1);
    hold(mask(4'h6), 1);
    hold(16'h0000, 2);
    check("3 then 6 accepts", acc_seen, 0);

    // Long hold, extra key during hold, release only of the first key.
    acc_seen = 0;
    hold(mask(4'h8), 5);
    hold(mask(4'h8) | mask(4'h9), 5);
    hold(mask(4'h9), 2);
    hold(16'h0000, 1);
    check("held 8 accepts", acc_seen, 1);
    check("held 8 key_code", bus.key_code, 4'h8);
    check("held 8 digits", bus.digits, 16'h0008);

    // Two keys together from idle.
    acc_seen = 0;
    hold(mask(4'h1) | mask(4'h2), 3);
    hold(16'h0000, 1);
    check("1+2 accepts", acc_seen, 0);

    // Reset while "4" is mid-debounce, key kept down across reset.
    hold(mask(4'h4), 1);
    run_round(mask(4'h4), 6);
    acc_seen = 0;
    hold(mask(4'h4), 2);
    check("post-reset no early accept", acc_seen, 0);
    hold(16'h0000, 1);
    check("post-reset accepts", acc_seen, 1);
    check("post-reset digits", bus.digits, 16'h0004);

    // Random key sets against the reference.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] keys;
      int kind;
      kind = $urandom_range(0, 4);
      keys = 16'h0000;
      if (kind >= 1) keys[$urandom_range(0, 15)] = 1'b1;
      if (kind == 4) keys[$urandom_range(0, 15)] = 1'b1;
      hold(keys, $urandom_range(1, 4));
    end
    hold(16'h0000, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
